// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: two-flop synchronizer, per-phase glitch filter,
// x4 Gray-code decode and a modulo-2^BITS up/down/load position counter.
module quad_decoder #(
    parameter int BITS = 16,
    parameter int FILT = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            a_in,
    input  logic            b_in,
    input  logic            load,
    input  logic [BITS-1:0] PI,
    input  logic            clr_err,
    output logic [BITS-1:0] Q,
    output logic            dir,
    output logic            step,
    output logic            err
);

    localparam int CW = $clog2(FILT + 1);
    localparam logic [CW-1:0] FILT_C = CW'(FILT);

    localparam logic [1:0] SYNC0 = 2'd0;
    localparam logic [1:0] SYNC1 = 2'd1;
    localparam logic [1:0] LOCK  = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    // Phase pairs are packed as {A,B}: bit 1 = A, bit 0 = B.
    logic [1:0]      state_q, state_d;
    logic [1:0]      s1_q, s2_q;
    logic [1:0]      f_q, f_d;
    logic [1:0]      p_q, p_d;
    logic [CW-1:0]   cnt_q [2];
    logic [CW-1:0]   cnt_d [2];
    logic [BITS-1:0] q_q, q_d;
    logic            dir_q, dir_d;
    logic            step_q, step_d;
    logic            err_q, err_d;

    logic            up, dn, bad;
    logic [CW-1:0]   inc;

    // Two-flop synchronizer for both phases.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {a_in, b_in};
            s2_q <= s1_q;
        end
    end

    // Next-state logic: start-up sequencing, filtering, decode, counter, err.
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q & ~clr_err;
        up      = 1'b0;
        dn      = 1'b0;
        bad     = 1'b0;
        inc     = '0;

        case (state_q)
            SYNC0: state_d = SYNC1;
            SYNC1: state_d = LOCK;
            LOCK: begin
                f_d = s2_q;
                p_d = s2_q;
                for (int unsigned i = 0; i < 2; i++) begin
                    cnt_d[i] = '0;
                end
                state_d = RUN;
            end
            default: begin
                // Filter: a phase flips only after FILT consecutive disagreeing samples.
                for (int unsigned i = 0; i < 2; i++) begin
                    if (s2_q[i] != f_q[i]) begin
                        inc = cnt_q[i] + CW'(1);
                        if (inc == FILT_C) begin
                            f_d[i]   = s2_q[i];
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = inc;
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
                end

                // Decode the previous filtered pair against the current one.
                p_d = f_q;
                case ({p_q, f_q})
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: up  = 1'b1;
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: dn  = 1'b1;
                    4'b0011, 4'b1100, 4'b1001, 4'b0110: bad = 1'b1;
                    default: ;
                endcase

                if (up || dn) begin
                    step_d = 1'b1;
                    dir_d  = up;
                    q_d    = up ? q_q + BITS'(1) : q_q - BITS'(1);
                end
                if (bad) begin
                    err_d = 1'b1;
                end
            end
        endcase

        // Load overrides the count but leaves step/dir from a coincident step.
        if (load) begin
            q_d = PI;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SYNC0;
            f_q     <= '0;
            p_q     <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            q_q     <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            p_q     <= p_d;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            q_q     <= q_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign Q    = q_q;
    assign dir  = dir_q;
    assign step = step_q;
    assign err  = err_q;

endmodule
